// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//
// Purpose:
//   Generates a burst of N count pulses for a level-filtered event counter.
//   Each high phase and each gap lasts at least MIN_LEN clocks, so every pulse
//   is long enough to get through the counter's active-level filter. A
//   start/busy/done handshake controls each burst.
//
// Ports:
//   i_clk       system clock; all logic is clocked on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     start request; sampled only in IDLE
//   i_num       number of pulses; latched when a start is accepted
//   i_high_len  pulse high length in clocks; latched on start (0 -> MIN_LEN)
//   i_low_len   gap length in clocks; latched on start (0 -> MIN_LEN)
//   o_pulse     pulse output; drives the counter clock input
//   o_cnt_en    high while a burst is active; drives the counter enable
//   o_busy      burst in progress
//   o_done      one-cycle strobe at the end of a burst
//   o_sent      pulses completed in the current or last burst
//   o_cnt_rst   (only with PULSE_TRAIN_GEN_CLR_EN) counter clear, 2 clocks
//
// Configuration:
//   PULSE_TRAIN_GEN_CLR_EN - when defined, adds the CLR state and the
//   o_cnt_rst output. An accepted start with i_num!=0 holds o_cnt_rst high
//   for 2 clocks before the first pulse.
// -----------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CNT_WIDTH = 8,
    parameter int TMR_WIDTH = 8,
    parameter int MIN_LEN   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_num,
    input  logic [TMR_WIDTH-1:0] i_high_len,
    input  logic [TMR_WIDTH-1:0] i_low_len,
    output logic                 o_pulse,
    output logic                 o_cnt_en,
    output logic                 o_busy,
    output logic                 o_done,
`ifdef PULSE_TRAIN_GEN_CLR_EN
    output logic                 o_cnt_rst,
`endif
    output logic [CNT_WIDTH-1:0] o_sent
);

    localparam logic [TMR_WIDTH-1:0] MIN_L = TMR_WIDTH'(MIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef PULSE_TRAIN_GEN_CLR_EN
        S_CLR,
`endif
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TMR_WIDTH-1:0] r_timer,  w_timer_next;
    logic [CNT_WIDTH-1:0] r_sent,   w_sent_next;
    logic [CNT_WIDTH-1:0] r_num,    w_num_next;
    logic [TMR_WIDTH-1:0] r_high,   w_high_next;
    logic [TMR_WIDTH-1:0] r_low,    w_low_next;
    logic [TMR_WIDTH-1:0] w_high_in_eff;
    logic [TMR_WIDTH-1:0] w_low_in_eff;

    logic r_pulse, r_cnt_en, r_busy, r_done;
`ifdef PULSE_TRAIN_GEN_CLR_EN
    logic r_cnt_rst;
`endif

    // Clamping to MIN_LEN also covers a length of 0.
    assign w_high_in_eff = (i_high_len < MIN_L) ? MIN_L : i_high_len;
    assign w_low_in_eff  = (i_low_len  < MIN_L) ? MIN_L : i_low_len;

    // Next-state logic. The phase timer is loaded with (length-1) on entry to
    // a phase and the phase ends when it reaches 0, so each phase lasts
    // exactly "length" clocks.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_sent_next  = r_sent;
        w_num_next   = r_num;
        w_high_next  = r_high;
        w_low_next   = r_low;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_sent_next = '0;
                    if (i_num != '0) begin
                        w_num_next  = i_num;
                        w_high_next = w_high_in_eff;
                        w_low_next  = w_low_in_eff;
`ifdef PULSE_TRAIN_GEN_CLR_EN
                        w_state_next = S_CLR;
                        w_timer_next = TMR_WIDTH'(1);
`else
                        w_state_next = S_HIGH;
                        w_timer_next = w_high_in_eff - TMR_WIDTH'(1);
`endif
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
`ifdef PULSE_TRAIN_GEN_CLR_EN
            S_CLR: begin
                if (r_timer == '0) begin
                    w_state_next = S_HIGH;
                    w_timer_next = r_high - TMR_WIDTH'(1);
                end else begin
                    w_timer_next = r_timer - TMR_WIDTH'(1);
                end
            end
`endif
            S_HIGH: begin
                if (r_timer == '0) begin
                    w_state_next = S_LOW;
                    w_timer_next = r_low - TMR_WIDTH'(1);
                    w_sent_next  = r_sent + CNT_WIDTH'(1);
                end else begin
                    w_timer_next = r_timer - TMR_WIDTH'(1);
                end
            end
            S_LOW: begin
                if (r_timer == '0) begin
                    if (r_sent == r_num) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_HIGH;
                        w_timer_next = r_high - TMR_WIDTH'(1);
                    end
                end else begin
                    w_timer_next = r_timer - TMR_WIDTH'(1);
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and have no path from any input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_sent    <= '0;
            r_num     <= '0;
            r_high    <= '0;
            r_low     <= '0;
            r_pulse   <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef PULSE_TRAIN_GEN_CLR_EN
            r_cnt_rst <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_sent    <= w_sent_next;
            r_num     <= w_num_next;
            r_high    <= w_high_next;
            r_low     <= w_low_next;
            r_pulse   <= (w_state_next == S_HIGH);
            r_busy    <= (w_state_next == S_HIGH) || (w_state_next == S_LOW)
`ifdef PULSE_TRAIN_GEN_CLR_EN
                         || (w_state_next == S_CLR)
`endif
                         ;
            r_cnt_en  <= (w_state_next == S_HIGH) || (w_state_next == S_LOW)
`ifdef PULSE_TRAIN_GEN_CLR_EN
                         || (w_state_next == S_CLR)
`endif
                         ;
            r_done    <= (w_state_next == S_DONE);
`ifdef PULSE_TRAIN_GEN_CLR_EN
            r_cnt_rst <= (w_state_next == S_CLR);
`endif
        end
    end

    assign o_pulse   = r_pulse;
    assign o_cnt_en  = r_cnt_en;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_sent    = r_sent;
`ifdef PULSE_TRAIN_GEN_CLR_EN
    assign o_cnt_rst = r_cnt_rst;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
//
// Directed bench for pulse_train_gen. Each accepted burst pushes its expected
// summary (final o_sent, busy clocks, pulse count, high and trailing gap
// lengths) onto a queue. A monitor measures the DUT waveform and compares
// against the head of the queue whenever o_done is seen.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

    localparam int CW = 8;
    localparam int TW = 8;
`ifdef PULSE_TRAIN_GEN_CLR_EN
    localparam int CLR_X = 2;
`else
    localparam int CLR_X = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num = '0;
    logic [TW-1:0] hlen = '0;
    logic [TW-1:0] llen = '0;
    logic          pulse, cnt_en, busy, done;
    logic [CW-1:0] sent;
`ifdef PULSE_TRAIN_GEN_CLR_EN
    logic          cnt_rst;
`endif

    pulse_train_gen #(.CNT_WIDTH(CW), .TMR_WIDTH(TW), .MIN_LEN(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_num      (num),
        .i_high_len (hlen),
        .i_low_len  (llen),
        .o_pulse    (pulse),
        .o_cnt_en   (cnt_en),
        .o_busy     (busy),
        .o_done     (done),
`ifdef PULSE_TRAIN_GEN_CLR_EN
        .o_cnt_rst  (cnt_rst),
`endif
        .o_sent     (sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sent;
        int busy_clks;
        int pulses;
        int hi;
        int lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   done_seen = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int mon_busy = 0, mon_pulses = 0, hi_run = 0, lo_run = 0, hi_len = 0;
    logic prev_pulse = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 0; mon_pulses = 0; hi_run = 0; lo_run = 0; hi_len = 0;
            prev_pulse = 1'b0; prev_done = 1'b0;
        end else begin
            if (pulse) check("pulse_inside_busy", int'(busy), 1);
            if (busy) mon_busy++;
            if (pulse && !prev_pulse) begin
                mon_pulses++;
                lo_run = 0;
            end
            if (pulse) begin
                hi_run++;
            end else begin
                if (prev_pulse) begin
                    hi_len = hi_run;
                    hi_run = 0;
                end
                if (busy) lo_run++;
            end
            if (done) begin
                check("done_one_cycle", int'(prev_done), 0);
                check("done_busy_low", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sent", int'(sent), e.sent);
                    check("busy_clks", mon_busy, e.busy_clks);
                    check("pulse_count", mon_pulses, e.pulses);
                    check("high_len", hi_len, e.hi);
                    check("low_len", lo_run, e.lo);
                    $display("burst done: sent=%0d busy=%0d pulses=%0d hi=%0d lo=%0d",
                             sent, mon_busy, mon_pulses, hi_len, lo_run);
                end
                mon_busy = 0; mon_pulses = 0; hi_run = 0; lo_run = 0; hi_len = 0;
                done_seen++;
            end
            prev_pulse = pulse;
            prev_done  = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int n, input int h, input int l);
        @(negedge clk);
        num = CW'(n); hlen = TW'(h); llen = TW'(l); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_seen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_seen < target) check("done_timeout", done_seen, target);
        @(negedge clk);
    endtask

    // Push the expected summary, start, wait.
    task automatic burst(input int n, input int h, input int l,
                         input int eh, input int el);
        exp_t e;
        int   tgt;
        e.sent = n;
        e.busy_clks = (n == 0) ? 0 : n * (eh + el) + CLR_X;
        e.pulses = n;
        e.hi = (n == 0) ? 0 : eh;
        e.lo = (n == 0) ? 0 : el;
        exp_q.push_back(e);
        tgt = done_seen + 1;
        issue(n, h, l);
        wait_done(tgt, e.busy_clks + 20);
    endtask

    initial begin
        exp_t e;
        int   tgt;

        // Test 1: reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom); num = CW'($urandom);
            hlen = TW'($urandom); llen = TW'($urandom);
            check("rst_outputs", int'({pulse, cnt_en, busy, done}), 0);
            check("rst_sent", int'(sent), 0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs", int'({pulse, cnt_en, busy, done}), 0);
        check("idle_sent", int'(sent), 0);

        // Test 2 with start latency check and an ignored mid-burst start.
        e.sent = 3; e.busy_clks = 120 + CLR_X; e.pulses = 3; e.hi = 20; e.lo = 20;
        exp_q.push_back(e);
        tgt = done_seen + 1;
        issue(3, 20, 20);
        check("start_busy", int'(busy), 1);
        check("start_cnt_en", int'(cnt_en), 1);
        check("start_sent_clr", int'(sent), 0);
`ifndef PULSE_TRAIN_GEN_CLR_EN
        check("start_pulse", int'(pulse), 1);
`endif
        repeat (30) @(negedge clk);
        num = 8'd7; hlen = 8'd100; llen = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tgt, 200);

        // Test 3: both lengths clamp to 16.
        burst(2, 4, 0, 16, 16);

        // Test 4: i_num = 0, done on the next clock.
        e.sent = 0; e.busy_clks = 0; e.pulses = 0; e.hi = 0; e.lo = 0;
        exp_q.push_back(e);
        tgt = done_seen + 1;
        @(negedge clk);
        num = 8'd0; hlen = 8'd20; llen = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done_next", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        wait_done(tgt, 10);

        // Boundary lengths: 17 gap, 255 high.
        burst(1, 16, 17, 16, 17);
        burst(1, 255, 16, 255, 16);

        // Test 5: reset in the middle of the 2nd HIGH phase.
        @(negedge clk);
        num = 8'd3; hlen = 8'd20; llen = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48 + CLR_X) @(negedge clk);
        check("mid_pulse", int'(pulse), 1);
        check("mid_sent", int'(sent), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pulse", int'(pulse), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sent", int'(sent), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        burst(1, 20, 18, 20, 18);

        // Test 6: long burst for counter loopback.
        burst(200, 16, 16, 16, 16);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
